sdram_burst_arbiter: RTL and testbench

- Schedules SDRAM burst requests for four FIFO ports: write ports 0/1 and read ports 0/1.
- Sits between the port FIFOs / fifo control and the SDRAM controller's wr/rd request interface.
- Grants one port at a time, round-robin, based on FIFO fill levels.
- Generates and wraps each port's SDRAM address within its own [b_addr, e_addr] region.
- Drives wr_sel/rd_sel so the datapath can steer ack and data to the granted FIFO.

---
 rtl/sdram_burst_arbiter.sv | 250 +++++++++++++++++++++++++
 tb/tb_sdram_burst_arbiter.sv | 282 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sdram_burst_arbiter.sv
// Round-robin scheduler for two write and two read FIFO ports in front of an SDRAM
// controller. It tracks a wrapping burst address per port and steers ack/data via wr_sel/rd_sel.
module sdram_burst_arbiter #(
    parameter int ADDR_W = 24,
    parameter int LEN_W  = 10,
    parameter int CNT_W  = 11
) (
    input  logic                  sys_clk,
    input  logic                  sys_rst_n,
    input  logic                  sdram_init_done,
    input  logic [CNT_W-1:0]      wr_fifo_num_0,
    input  logic [CNT_W-1:0]      wr_fifo_num_1,
    input  logic [CNT_W-1:0]      rd_fifo_num_0,
    input  logic [CNT_W-1:0]      rd_fifo_num_1,
    input  logic [4*ADDR_W-1:0]   port_b_addr,
    input  logic [4*ADDR_W-1:0]   port_e_addr,
    input  logic [3:0]            addr_rst,
    input  logic [LEN_W-1:0]      wr_burst_len,
    input  logic [LEN_W-1:0]      rd_burst_len,
    input  logic                  sdram_read_valid,
    input  logic                  sdram_wr_ack,
    input  logic                  sdram_rd_ack,
    output logic                  sdram_wr_req,
    output logic [ADDR_W-1:0]     sdram_wr_addr,
    output logic                  sdram_rd_req,
    output logic [ADDR_W-1:0]     sdram_rd_addr,
    output logic                  wr_sel,
    output logic                  rd_sel,
    output logic [1:0]            grant_id
);
    localparam int CMP_W = (CNT_W > LEN_W) ? CNT_W : LEN_W;
    localparam int NXT_W = ADDR_W + 1;
    localparam int END_W = ADDR_W + 2;

    typedef enum logic [2:0] {
        S_IDLE,
        S_ARB,
        S_WR_KEEP,
        S_WR_DONE,
        S_RD_KEEP,
        S_RD_DONE
    } state_t;

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] ptr_q [4];
    logic [ADDR_W-1:0] ptr_d [4];
    logic [3:0]        pend_q, pend_d;
    logic [1:0]        last_grant_q, last_grant_d;
    logic [1:0]        grant_id_q, grant_id_d;
    logic              wr_req_q, wr_req_d;
    logic              rd_req_q, rd_req_d;
    logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
    logic [ADDR_W-1:0] rd_addr_q, rd_addr_d;
    logic              wr_sel_q, wr_sel_d;
    logic              rd_sel_q, rd_sel_d;
    logic              wr_ack_q, rd_ack_q;

    logic [ADDR_W-1:0] b_addr [4];
    logic [ADDR_W-1:0] e_addr [4];
    logic [CNT_W-1:0]  fifo_num [4];
    logic [3:0]        elig;

    assign fifo_num[0] = wr_fifo_num_0;
    assign fifo_num[1] = wr_fifo_num_1;
    assign fifo_num[2] = rd_fifo_num_0;
    assign fifo_num[3] = rd_fifo_num_1;

    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_port
            assign b_addr[gi] = port_b_addr[gi*ADDR_W +: ADDR_W];
            assign e_addr[gi] = port_e_addr[gi*ADDR_W +: ADDR_W];
            if (gi < 2) begin : g_wr
                // A write burst is worth issuing only once a full burst of data is buffered.
                assign elig[gi] = (wr_burst_len != '0) &&
                                  (CMP_W'(fifo_num[gi]) >= CMP_W'(wr_burst_len));
            end else begin : g_rd
                assign elig[gi] = sdram_read_valid && (rd_burst_len != '0) &&
                                  (CMP_W'(fifo_num[gi]) < CMP_W'(rd_burst_len));
            end
        end
    endgenerate

    logic       win_found;
    logic [1:0] win_idx;
    logic [1:0] cand;

    always_comb begin
        win_found = 1'b0;
        win_idx   = '0;
        cand      = '0;
        for (int k = 1; k <= 4; k++) begin
            cand = last_grant_q + 2'(k);
            if (!win_found && elig[cand]) begin
                win_found = 1'b1;
                win_idx   = cand;
            end
        end
    end

    logic [LEN_W-1:0]  act_len;
    logic [NXT_W-1:0]  nxt;
    logic [END_W-1:0]  nxt_end;
    logic [ADDR_W-1:0] adv_ptr;

    // Wrap early if the following burst would run past the region end.
    always_comb begin
        act_len = (state_q == S_WR_DONE) ? wr_burst_len : rd_burst_len;
        nxt     = NXT_W'(ptr_q[last_grant_q]) + NXT_W'(act_len);
        nxt_end = END_W'(nxt) + END_W'(act_len);
        adv_ptr = (nxt_end > END_W'(e_addr[last_grant_q])) ? b_addr[last_grant_q]
                                                           : nxt[ADDR_W-1:0];
    end

    logic burst_active;
    assign burst_active = (state_q == S_WR_KEEP) || (state_q == S_WR_DONE) ||
                          (state_q == S_RD_KEEP) || (state_q == S_RD_DONE);

    always_comb begin
        state_d      = state_q;
        pend_d       = pend_q;
        last_grant_d = last_grant_q;
        grant_id_d   = grant_id_q;
        wr_req_d     = wr_req_q;
        rd_req_d     = rd_req_q;
        wr_addr_d    = wr_addr_q;
        rd_addr_d    = rd_addr_q;
        wr_sel_d     = wr_sel_q;
        rd_sel_d     = rd_sel_q;
        for (int i = 0; i < 4; i++) begin
            ptr_d[i] = ptr_q[i];
        end

        // The port owning the current burst defers its reload until the burst retires.
        for (int i = 0; i < 4; i++) begin
            if (addr_rst[i]) begin
                if (burst_active && (last_grant_q == 2'(i))) begin
                    pend_d[i] = 1'b1;
                end else begin
                    ptr_d[i] = b_addr[i];
                end
            end
        end

        case (state_q)
            S_IDLE: begin
                wr_req_d = 1'b0;
                rd_req_d = 1'b0;
                pend_d   = '0;
                for (int i = 0; i < 4; i++) begin
                    ptr_d[i] = b_addr[i];
                end
                if (sdram_init_done) begin
                    state_d = S_ARB;
                end
            end
            S_ARB: begin
                wr_req_d = 1'b0;
                rd_req_d = 1'b0;
                if (win_found) begin
                    last_grant_d = win_idx;
                    grant_id_d   = win_idx;
                    if (!win_idx[1]) begin
                        wr_addr_d = ptr_q[win_idx];
                        wr_sel_d  = win_idx[0];
                        wr_req_d  = 1'b1;
                        state_d   = S_WR_KEEP;
                    end else begin
                        rd_addr_d = ptr_q[win_idx];
                        rd_sel_d  = win_idx[0];
                        rd_req_d  = 1'b1;
                        state_d   = S_RD_KEEP;
                    end
                end
            end
            S_WR_KEEP: begin
                if (sdram_wr_ack) begin
                    wr_req_d = 1'b0;
                end
                if (wr_ack_q && !sdram_wr_ack) begin
                    state_d = S_WR_DONE;
                end
            end
            S_RD_KEEP: begin
                if (sdram_rd_ack) begin
                    rd_req_d = 1'b0;
                end
                if (rd_ack_q && !sdram_rd_ack) begin
                    state_d = S_RD_DONE;
                end
            end
            S_WR_DONE, S_RD_DONE: begin
                ptr_d[last_grant_q]  = (pend_q[last_grant_q] || addr_rst[last_grant_q]) ?
                                       b_addr[last_grant_q] : adv_ptr;
                pend_d[last_grant_q] = 1'b0;
                state_d              = S_ARB;
            end
            default: begin
                state_d  = S_IDLE;
                wr_req_d = 1'b0;
                rd_req_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state_q      <= S_IDLE;
            pend_q       <= '0;
            last_grant_q <= 2'd3;
            grant_id_q   <= '0;
            wr_req_q     <= 1'b0;
            rd_req_q     <= 1'b0;
            wr_addr_q    <= '0;
            rd_addr_q    <= '0;
            wr_sel_q     <= 1'b0;
            rd_sel_q     <= 1'b0;
            wr_ack_q     <= 1'b0;
            rd_ack_q     <= 1'b0;
            for (int i = 0; i < 4; i++) begin
                ptr_q[i] <= '0;
            end
        end else begin
            state_q      <= state_d;
            pend_q       <= pend_d;
            last_grant_q <= last_grant_d;
            grant_id_q   <= grant_id_d;
            wr_req_q     <= wr_req_d;
            rd_req_q     <= rd_req_d;
            wr_addr_q    <= wr_addr_d;
            rd_addr_q    <= rd_addr_d;
            wr_sel_q     <= wr_sel_d;
            rd_sel_q     <= rd_sel_d;
            wr_ack_q     <= sdram_wr_ack;
            rd_ack_q     <= sdram_rd_ack;
            for (int i = 0; i < 4; i++) begin
                ptr_q[i] <= ptr_d[i];
            end
        end
    end

    assign sdram_wr_req  = wr_req_q;
    assign sdram_rd_req  = rd_req_q;
    assign sdram_wr_addr = wr_addr_q;
    assign sdram_rd_addr = rd_addr_q;
    assign wr_sel        = wr_sel_q;
    assign rd_sel        = rd_sel_q;
    assign grant_id      = grant_id_q;

endmodule

// File: tb/tb_sdram_burst_arbiter.sv
// Bench for sdram_burst_arbiter: acts as the SDRAM controller and compares every grant
// against a transaction-level model of round-robin scheduling and per-port address wrapping.
module tb_sdram_burst_arbiter;
    localparam int ADDR_W = 24;
    localparam int LEN_W  = 10;
    localparam int CNT_W  = 11;

    logic                 clk = 1'b0;
    logic                 rst_n;
    logic                 init_done;
    logic [CNT_W-1:0]     wnum [2];
    logic [CNT_W-1:0]     rnum [2];
    logic [4*ADDR_W-1:0]  port_b_addr;
    logic [4*ADDR_W-1:0]  port_e_addr;
    logic [3:0]           addr_rst;
    logic [LEN_W-1:0]     wr_len;
    logic [LEN_W-1:0]     rd_len;
    logic                 read_valid;
    logic                 wr_ack;
    logic                 rd_ack;
    logic                 wr_req;
    logic [ADDR_W-1:0]    wr_addr;
    logic                 rd_req;
    logic [ADDR_W-1:0]    rd_addr;
    logic                 wr_sel;
    logic                 rd_sel;
    logic [1:0]           grant_id;

    always #5 clk = ~clk;

    sdram_burst_arbiter #(.ADDR_W(ADDR_W), .LEN_W(LEN_W), .CNT_W(CNT_W)) dut (
        .sys_clk          (clk),
        .sys_rst_n        (rst_n),
        .sdram_init_done  (init_done),
        .wr_fifo_num_0    (wnum[0]),
        .wr_fifo_num_1    (wnum[1]),
        .rd_fifo_num_0    (rnum[0]),
        .rd_fifo_num_1    (rnum[1]),
        .port_b_addr      (port_b_addr),
        .port_e_addr      (port_e_addr),
        .addr_rst         (addr_rst),
        .wr_burst_len     (wr_len),
        .rd_burst_len     (rd_len),
        .sdram_read_valid (read_valid),
        .sdram_wr_ack     (wr_ack),
        .sdram_rd_ack     (rd_ack),
        .sdram_wr_req     (wr_req),
        .sdram_wr_addr    (wr_addr),
        .sdram_rd_req     (rd_req),
        .sdram_rd_addr    (rd_addr),
        .wr_sel           (wr_sel),
        .rd_sel           (rd_sel),
        .grant_id         (grant_id)
    );

    int vectors    = 0;
    int miscompares = 0;
    int mutex_viol = 0;

    // Reference model: per-port region, pointer, pending reload and last grant.
    longint unsigned mb [4];
    longint unsigned me [4];
    longint unsigned mptr [4];
    bit              mpend [4];
    int              mlast;

    task automatic chk(input string tag, input longint unsigned obs, input longint unsigned exp);
        vectors++;
        if (obs !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    always @(negedge clk) begin
        if (wr_req && rd_req) mutex_viol++;
    end

    function automatic bit port_ready(input int p);
        if (p < 2) return (wr_len != 0) && (int'(wnum[p]) >= int'(wr_len));
        return read_valid && (rd_len != 0) && (int'(rnum[p-2]) < int'(rd_len));
    endfunction

    function automatic int pick();
        for (int k = 1; k <= 4; k++) begin
            if (port_ready((mlast + k) % 4)) return (mlast + k) % 4;
        end
        return -1;
    endfunction

    task automatic apply_cfg();
        for (int i = 0; i < 4; i++) begin
            port_b_addr[i*ADDR_W +: ADDR_W] = ADDR_W'(mb[i]);
            port_e_addr[i*ADDR_W +: ADDR_W] = ADDR_W'(me[i]);
        end
    endtask

    task automatic do_reset(input int hold);
        bit quiet;
        rst_n = 1'b0; init_done = 1'b0; wr_ack = 1'b0; rd_ack = 1'b0; addr_rst = '0;
        apply_cfg();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            mptr[i] = mb[i];
            mpend[i] = 1'b0;
        end
        mlast = 3;
        quiet = 1'b1;
        repeat (hold) begin
            @(negedge clk);
            if (wr_req || rd_req) quiet = 1'b0;
        end
        chk("idle_quiet", quiet, 1);
        init_done = 1'b1;
    endtask

    // One scheduling round: predict the winner, play the controller, retire the burst.
    task automatic run_txn(input logic [3:0] rst_mask, output int lat, output int got_port,
                           output longint unsigned got_addr);
        int p;
        bit seen;
        longint unsigned len, nxt;
        p = pick();
        lat = 0; got_port = -1; got_addr = 0;
        if (p < 0) begin
            repeat (4) begin
                @(negedge clk);
                chk("quiet", {wr_req, rd_req}, 0);
            end
            return;
        end
        seen = 1'b0;
        while (!seen && lat < 4) begin
            @(negedge clk);
            lat++;
            if (wr_req || rd_req) seen = 1'b1;
        end
        chk("req_seen", seen, 1);
        if (!seen) return;
        got_port = int'(grant_id);
        got_addr = (p < 2) ? wr_addr : rd_addr;
        chk("grant_id", grant_id, p);
        chk("wr_req", wr_req, (p < 2));
        chk("rd_req", rd_req, (p >= 2));
        if (p < 2) chk("wr_sel", wr_sel, p);
        else       chk("rd_sel", rd_sel, p - 2);
        chk("addr", got_addr, mptr[p]);
        mlast = p;
        repeat ($urandom_range(0, 2)) begin
            @(negedge clk);
            chk("req_hold", (p < 2) ? wr_req : rd_req, 1);
        end
        if (p < 2) wr_ack = 1'b1; else rd_ack = 1'b1;
        @(negedge clk);
        chk("req_drop", (p < 2) ? wr_req : rd_req, 0);
        if (rst_mask != 0) begin
            addr_rst = rst_mask;
            @(negedge clk);
            addr_rst = '0;
            for (int i = 0; i < 4; i++) begin
                if (rst_mask[i]) begin
                    if (i == p) mpend[i] = 1'b1;
                    else        mptr[i]  = mb[i];
                end
            end
        end
        repeat ($urandom_range(0, 2)) @(negedge clk);
        wr_ack = 1'b0; rd_ack = 1'b0;
        @(negedge clk);
        @(negedge clk);
        len = (p < 2) ? longint'(wr_len) : longint'(rd_len);
        nxt = mptr[p] + len;
        if (mpend[p])             mptr[p] = mb[p];
        else if (nxt + len > me[p]) mptr[p] = mb[p];
        else                      mptr[p] = nxt;
        mpend[p] = 1'b0;
    endtask

    int lat, port;
    longint unsigned addr;
    longint unsigned exp2 [5] = '{0, 256, 512, 768, 0};
    longint unsigned exp3 [3] = '{'h100, 'h200, 'h100};
    bit seen_rd;

    initial begin
        rst_n = 1'b0; init_done = 1'b0; addr_rst = '0; wr_ack = 1'b0; rd_ack = 1'b0;
        read_valid = 1'b0; wr_len = '0; rd_len = '0;
        wnum[0] = '0; wnum[1] = '0; rnum[0] = '0; rnum[1] = '0;
        for (int i = 0; i < 4; i++) begin
            mb[i] = 'h1000 * i;
            me[i] = mb[i] + 'h800;
        end
        mb[0] = 0; me[0] = 1024;
        apply_cfg();
        #1;
        chk("rst_wr_req", wr_req, 0);
        chk("rst_rd_req", rd_req, 0);
        chk("rst_grant", grant_id, 0);
        chk("rst_wr_addr", wr_addr, 0);
        chk("rst_sel", {wr_sel, rd_sel}, 0);

        // Reset release with init held low, then a single write port streaming.
        wr_len = 256; wnum[0] = 300;
        do_reset(20);
        for (int k = 0; k < 5; k++) begin
            run_txn('0, lat, port, addr);
            if (k == 0) chk("init_latency", lat, 2);
            chk("t2_addr", addr, exp2[k]);
            chk("t2_port", port, 0);
        end

        // Early wrap when the next burst would overrun the region end.
        mb[0] = 'h100; me[0] = 'h350;
        do_reset(2);
        for (int k = 0; k < 3; k++) begin
            run_txn('0, lat, port, addr);
            chk("t3_addr", addr, exp3[k]);
        end

        // All four ports eligible: strict rotation.
        mb[0] = 0; me[0] = 'h800;
        wr_len = 64; rd_len = 64; wnum[0] = 512; wnum[1] = 512;
        rnum[0] = 0; rnum[1] = 0; read_valid = 1'b1;
        do_reset(2);
        for (int k = 0; k < 9; k++) begin
            run_txn('0, lat, port, addr);
            chk("t4_rr", port, k % 4);
        end

        // addr_rst on the active port is deferred until the burst retires.
        read_valid = 1'b0; wr_len = 'h100; wnum[0] = 0; wnum[1] = 300;
        mb[1] = 'h300; me[1] = 'h1000;
        do_reset(2);
        run_txn('0, lat, port, addr);
        chk("t5_first", addr, 'h300);
        run_txn(4'b0010, lat, port, addr);
        chk("t5_mid", addr, 'h400);
        run_txn('0, lat, port, addr);
        chk("t5_reload", addr, 'h300);

        // Asynchronous reset while a read request is pending.
        wr_len = 0; wnum[1] = 0; rd_len = 32; rnum[0] = 0; read_valid = 1'b1;
        do_reset(2);
        seen_rd = 1'b0;
        for (int n = 0; n < 4 && !seen_rd; n++) begin
            @(negedge clk);
            if (rd_req) seen_rd = 1'b1;
        end
        chk("t6_rd_req_up", seen_rd, 1);
        rst_n = 1'b0;
        #1;
        chk("t6_rst_rd_req", rd_req, 0);
        chk("t6_rst_grant", grant_id, 0);
        wr_len = 32; wnum[0] = 100;
        do_reset(3);
        run_txn('0, lat, port, addr);
        chk("t6_first_grant", port, 0);

        // Randomized regions, lengths, fill levels and address reloads.
        for (int i = 0; i < 4; i++) begin
            mb[i] = 'h10000 * i + 16 * $urandom_range(0, 255);
            me[i] = mb[i] + $urandom_range('h40, 'h1000);
        end
        do_reset(2);
        for (int t = 0; t < 150; t++) begin
            wr_len     = ($urandom_range(0, 7) == 0) ? '0 : LEN_W'($urandom_range(1, 300));
            rd_len     = ($urandom_range(0, 7) == 0) ? '0 : LEN_W'($urandom_range(1, 300));
            wnum[0]    = CNT_W'($urandom_range(0, 511));
            wnum[1]    = CNT_W'($urandom_range(0, 511));
            rnum[0]    = CNT_W'($urandom_range(0, 300));
            rnum[1]    = CNT_W'($urandom_range(0, 300));
            read_valid = 1'($urandom_range(0, 1));
            run_txn(($urandom_range(0, 5) == 0) ? 4'($urandom_range(1, 15)) : 4'b0000,
                    lat, port, addr);
        end

        chk("mutex", mutex_viol, 0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
